// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero is flagged after a single cycle, with an all-ones quotient.
module seq_restoring_divider #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  typedef enum logic [1:0] {IDLE, RUN, DZ} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH:0]   rem, rem_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] dvsr, dvsr_next;
  logic [WIDTH-1:0] quot_out_next, rem_out_next;
  logic             dz_next, done_next;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    rem_next      = rem;
    quo_next      = quo;
    dvsr_next     = dvsr;
    quot_out_next = quotient_o;
    rem_out_next  = remainder_o;
    dz_next       = div_by_zero_o;
    done_next     = 1'b0;
    // The partial remainder is one bit wider than the divisor, so the trial
    // subtraction's MSB is a clean borrow flag.
    shifted       = {rem, quo} << 1;
    trial         = shifted[2*WIDTH:WIDTH] - {1'b0, dvsr};

    case (state)
      IDLE: begin
        if (start_i) begin
          quo_next  = dividend_i;
          dvsr_next = divisor_i;
          rem_next  = '0;
          if (divisor_i == '0) begin
            state_next = DZ;
            cnt_next   = '0;
          end else begin
            state_next = RUN;
            cnt_next   = CNT_W'(WIDTH);
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_next = trial;
          quo_next = {shifted[WIDTH-1:1], 1'b1};
        end else begin
          rem_next = shifted[2*WIDTH:WIDTH];
          quo_next = {shifted[WIDTH-1:1], 1'b0};
        end
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          quot_out_next = quo_next;
          rem_out_next  = rem_next[WIDTH-1:0];
          dz_next       = 1'b0;
          done_next     = 1'b1;
          state_next    = IDLE;
        end
      end
      DZ: begin
        quot_out_next = '1;
        rem_out_next  = quo;
        dz_next       = 1'b1;
        done_next     = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      dvsr          <= '0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      rem           <= rem_next;
      quo           <= quo_next;
      dvsr          <= dvsr_next;
      quotient_o    <= quot_out_next;
      remainder_o   <= rem_out_next;
      div_by_zero_o <= dz_next;
      done_o        <= done_next;
    end
  end

  assign busy_o = (state != IDLE);

endmodule
